// File: rtl/icache_line_filler_if.sv
// Refill bus between the ICache, the line filler and the instruction ROM.
// slave: the filler side; master: the cache/ROM side (drives requests and ROM returns).
interface icache_line_filler_if #(
  parameter int BLOCK_SIZE = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    memRead;
  logic [ADDR_WIDTH-1:0]   memAddress;
  logic                    memBusy;
  logic [BLOCK_SIZE*8-1:0] memReadData;
  logic                    romReq;
  logic [ADDR_WIDTH-1:0]   romAddr;
  logic                    romValid;
  logic [31:0]             romData;

  modport slave (
    input  memRead, memAddress, romValid, romData,
    output memBusy, memReadData, romReq, romAddr
  );

  modport master (
    output memRead, memAddress, romValid, romData,
    input  memBusy, memReadData, romReq, romAddr
  );
endinterface

// File: rtl/icache_line_filler.sv
// ICache line refill engine: reads one block word-by-word from the ROM and
// returns the assembled line, with memBusy high for the whole refill.
module icache_line_filler #(
  parameter int BLOCK_SIZE = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  icache_line_filler_if.slave  bus
);
  localparam int NW = BLOCK_SIZE / 4;
  localparam int IW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   base;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_inc;
  logic                    last_word;
  logic [BLOCK_SIZE*8-1:0] line_buf;
  logic [ADDR_WIDTH-1:0]   aligned;
  logic                    busy_r;
  logic [BLOCK_SIZE*8-1:0] data_r;
  logic                    req_r;
  logic [ADDR_WIDTH-1:0]   addr_r;

  assign aligned   = bus.memAddress & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
  assign idx_inc   = idx + 1'b1;
  assign last_word = (idx == IW'(NW - 1));

  assign bus.memBusy     = busy_r;
  assign bus.memReadData = data_r;
  assign bus.romReq      = req_r;
  assign bus.romAddr     = addr_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.memRead) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.romValid) state_nx = last_word ? COMMIT : ISSUE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: romReq/romAddr are registered on the edge entering ISSUE so they
  // are valid during the ISSUE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      idx      <= '0;
      line_buf <= '0;
      busy_r   <= 1'b0;
      data_r   <= '0;
      req_r    <= 1'b0;
      addr_r   <= '0;
    end else begin
      req_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.memRead) begin
            base   <= aligned;
            idx    <= '0;
            busy_r <= 1'b1;
            req_r  <= 1'b1;
            addr_r <= aligned;
          end
        end
        WAIT: begin
          if (bus.romValid) begin
            line_buf[{idx, 5'd0} +: 32] <= bus.romData;
            if (!last_word) begin
              idx    <= idx_inc;
              req_r  <= 1'b1;
              addr_r <= base + (ADDR_WIDTH'(idx_inc) << 2);
            end
          end
        end
        COMMIT: begin
          data_r <= line_buf;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
